serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Parametrised bit-serial adder/subtractor. Successor to the combinational half-adder cell.
- Accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a single full-adder cell.
- Reports sum, carry/borrow and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators and checksum paths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled only when not busy.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1); sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- sum  output  WIDTH  result bits.
- carry  output  1  carry-out of the MSB. In sub mode, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, carry, overflow = 0; internal shift registers, bit counter and carry flop = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch a, latch (sub ? ~b : b), set the carry flop to (sub ? 1 : cin), clear the counter, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge: full adder on the current LSBs of the A/B shift registers plus the carry flop. The result bit shifts into the MSB of the result register, the operand registers shift right, the carry flop updates, and the counter increments.
  - After the edge that processes bit WIDTH-1, go to DONE.
- DONE:
  - At the transition edge, sum, carry and overflow are written from internal state. done=1 and busy=0 for exactly one cycle.
  - overflow uses the carry into bit WIDTH-1, captured during the final RUN cycle.
  - Next edge: go to IDLE. If start=1 in DONE, accept new operands and go directly to RUN (back-to-back operation, no idle bubble).
- Latency: the edge that samples start is edge 0. done is high in the cycle following edge WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while in RUN: ignored, no queuing. Operand changes during RUN have no effect.
- sum, carry and overflow hold their last values until the next completion. They never show partial results.
- WIDTH=1:
  - One RUN cycle; the counter is at least 1 bit wide.
  - overflow = cin_into_bit0 XOR carry_out.
- Reset asserted mid-RUN: the operation aborts immediately, with no done pulse. After release the block is in IDLE.
- Arithmetic is modulo 2^WIDTH. carry is bit WIDTH of the full-precision result.

Decomposition:
- Shared package adder_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - function cnt_w(WIDTH) = max(1, clog2(WIDTH)).
- Sub-module full_add:
  - ports a, b, cin, sum, carry;
  - built from two half_add instances plus an OR gate.
  - serial_add instantiates exactly one full_add.

Test Plan:
- WIDTH=8, add a=200, b=100, cin=0 -> after WIDTH+1 cycles: done pulse, sum=44, carry=1, overflow=0.
- WIDTH=8, add a=100, b=50, cin=1 -> sum=151, carry=0, overflow=1. busy high for exactly 8 cycles.
- WIDTH=8, sub a=5, b=7 -> sum=254, carry=0 (borrow), overflow=0. Then sub a=0x80, b=1 -> sum=0x7F, carry=1, overflow=1.
- Back-to-back: start held in DONE with a=255, b=1, add -> no idle cycle, done 9 cycles later, sum=0, carry=1.
- Reset mid-RUN: assert rst_n=0 after 3 RUN cycles -> outputs 0 asynchronously and no done pulse. Restart a=3, b=4 -> sum=7.
- WIDTH=1 and WIDTH=16 instances:
  - WIDTH=1: a=1, b=1, cin=1 -> sum=1, carry=1.
  - WIDTH=16: random add/sub versus a reference model over 1000 operations, with start pulses also issued during RUN (these must be ignored).

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the controller state encoding and the bit-counter width rule.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter must index 0..WIDTH-1 and stay at least one bit wide when WIDTH is 1.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_add.sv
// Single-bit full adder built from two half adders and an OR gate.
// This is the only arithmetic cell the serial adder uses.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic s1;
    logic c1;
    logic c2;

    half_add u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s1),
        .carry (c1)
    );

    half_add u_ha1 (
        .a     (s1),
        .b     (cin),
        .sum   (sum),
        .carry (c2)
    );

    assign carry = c1 | c2;

endmodule

// File: rtl/half_add.sv
// Single-bit half adder; two of these plus an OR form the full-adder cell.
module half_add (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through one full adder.
// Results (sum, carry, signed overflow) are published together with a one-cycle done pulse.
module serial_add
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    full_add u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New result bit enters at the MSB so that after WIDTH shifts it lines up LSB-aligned.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_d = fa_sum;
        end else begin : g_res_wn
            assign res_d = {fa_sum, res_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // Subtraction is a + ~b + 1: invert B here and preload the carry with 1.
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        c_q     <= sub ? 1'b1 : cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    c_q   <= fa_carry;
                    cnt_q <= cnt_q + CW'(1);
                    // c_q still holds the carry into the MSB while the last bit is processed.
                    if (last_bit) begin
                        sum      <= res_d;
                        carry    <= fa_carry;
                        overflow <= c_q ^ fa_carry;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add at WIDTH 8, 1 and 16 against an integer reference model.
// Stimulus pushes expected results; per-instance monitors pop and compare on each done pulse.
module tb_serial_add;

    typedef struct {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s8 = 0, cin8 = 0, sub8 = 0, busy8, done8, c8, ov8;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic        s1 = 0, cin1 = 0, sub1 = 0, busy1, done1, c1, ov1;
    logic [0:0]  a1 = 0, b1 = 0, sum1;
    logic        s16 = 0, cin16 = 0, sub16 = 0, busy16, done16, c16, ov16;
    logic [15:0] a16 = 0, b16 = 0, sum16;

    serial_add #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(c8), .overflow(ov8)
    );
    serial_add #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(c1), .overflow(ov1)
    );
    serial_add #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(c16), .overflow(ov16)
    );

    exp_t q8[$];
    exp_t q1[$];
    exp_t q16[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
    function automatic exp_t ref_model(input int w, input longint a, input longint b,
                                       input bit cin, input bit sub);
        exp_t   e;
        longint mod, mask, sa, sb, sres, full;
        mod  = longint'(1) << w;
        mask = mod - 1;
        sa   = (a >= mod / 2) ? a - mod : a;
        sb   = (b >= mod / 2) ? b - mod : b;
        if (!sub) begin
            full    = a + b + longint'(cin);
            e.carry = (full >= mod);
            sres    = sa + sb + longint'(cin);
        end else begin
            full    = a - b;
            e.carry = (a >= b);
            sres    = sa - sb;
        end
        e.sum = 64'(full & mask);
        e.ovf = (sres < -(mod / 2)) || (sres > (mod / 2) - 1);
        return e;
    endfunction

    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            chk("w8 done has scoreboard entry", 64'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("w8 sum", 64'(sum8), e.sum);
                chk("w8 carry", 64'(c8), 64'(e.carry));
                chk("w8 overflow", 64'(ov8), 64'(e.ovf));
                $display("w8 op: sum=0x%0h carry=%0d ovf=%0d", sum8, c8, ov8);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1) begin
            chk("w1 done has scoreboard entry", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("w1 sum", 64'(sum1), e.sum);
                chk("w1 carry", 64'(c1), 64'(e.carry));
                chk("w1 overflow", 64'(ov1), 64'(e.ovf));
                $display("w1 op: sum=%0d carry=%0d ovf=%0d", sum1, c1, ov1);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16) begin
            chk("w16 done has scoreboard entry", 64'(q16.size() != 0), 1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("w16 sum", 64'(sum16), e.sum);
                chk("w16 carry", 64'(c16), 64'(e.carry));
                chk("w16 overflow", 64'(ov16), 64'(e.ovf));
                $display("w16 op: sum=0x%0h carry=%0d ovf=%0d", sum16, c16, ov16);
            end
        end
    end

    // Called at a negedge; start is accepted at the following posedge (edge 0).
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit cin,
                          input bit sub, input bit push);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; s8 = 1'b1;
        if (push) q8.push_back(ref_model(8, longint'(a), longint'(b), cin, sub));
        @(posedge clk);
        #1 s8 = 1'b0;
    endtask

    // Returns at the negedge where done is seen: that sample is WIDTH+1 after edge 0.
    task automatic wait8();
        int n = 0;
        int nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end while (!done8 && n < 40);
        chk("w8 done latency", 64'(n), 9);
        chk("w8 busy cycles", 64'(nb), 8);
    endtask

    task automatic run16(input bit chain);
        logic [15:0] ra, rb;
        bit rc, rs;
        int inj, n, nb;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        if (!chain) @(negedge clk);
        a16 = ra; b16 = rb; cin16 = rc; sub16 = rs; s16 = 1'b1;
        q16.push_back(ref_model(16, longint'(ra), longint'(rb), rc, rs));
        @(posedge clk);
        #1 s16 = 1'b0;
        inj = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 14));
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy16) nb++;
            // A start raised mid-run, with scrambled operands, must be ignored.
            if (n == inj) begin
                s16 = 1'b1;
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                sub16 = ~sub16;
            end else begin
                s16 = 1'b0;
            end
        end while (!done16 && n < 60);
        s16 = 1'b0;
        chk("w16 done latency", 64'(n), 17);
        chk("w16 busy cycles", 64'(nb), 16);
    endtask

    initial begin
        int n, nb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset w8 busy", 64'(busy8), 0);
        chk("reset w8 done", 64'(done8), 0);
        chk("reset w8 sum", 64'(sum8), 0);
        chk("reset w8 carry/ovf", 64'({c8, ov8}), 0);
        chk("reset w1 outputs", 64'({busy1, done1, sum1, c1, ov1}), 0);
        chk("reset w16 outputs", 64'({busy16, done16, sum16, c16, ov16}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue8(8'd200, 8'd100, 1'b0, 1'b0, 1'b1); wait8(); @(negedge clk);
        issue8(8'd100, 8'd50,  1'b1, 1'b0, 1'b1); wait8(); @(negedge clk);
        issue8(8'd5,   8'd7,   1'b1, 1'b1, 1'b1); wait8(); @(negedge clk);
        issue8(8'h80,  8'h01,  1'b0, 1'b1, 1'b1); wait8(); @(negedge clk);

        // Abort mid-run: reset lands between clock edges and must clear outputs at once.
        issue8(8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset w8 busy", 64'(busy8), 0);
        chk("async reset w8 sum", 64'(sum8), 0);
        chk("async reset w8 carry/ovf/done", 64'({c8, ov8, done8}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("w8 idle after reset", 64'(busy8), 0);

        issue8(8'd3, 8'd4, 1'b0, 1'b0, 1'b1); wait8();
        issue8(8'd255, 8'd1, 1'b0, 1'b0, 1'b1); wait8(); @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b1);
            wait8();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0; s1 = 1'b1;
        q1.push_back(ref_model(1, 1, 1, 1'b1, 1'b0));
        @(posedge clk);
        #1 s1 = 1'b0;
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy1) nb++;
        end while (!done1 && n < 20);
        chk("w1 done latency", 64'(n), 2);
        chk("w1 busy cycles", 64'(nb), 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            cin1 = 1'($urandom); sub1 = 1'($urandom); s1 = 1'b1;
            q1.push_back(ref_model(1, longint'(a1), longint'(b1), cin1, sub1));
            @(posedge clk);
            #1 s1 = 1'b0;
            repeat (3) @(negedge clk);
        end

        for (int i = 0; i < 1000; i++) begin
            run16(i > 0 && $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        chk("w8 scoreboard drained", 64'(q8.size()), 0);
        chk("w1 scoreboard drained", 64'(q1.size()), 0);
        chk("w16 scoreboard drained", 64'(q16.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
